// File: rtl/dap_swd_xfer_engine_pkg.sv
// Shared constants for the DAP SWD transfer engine: sequencer command code, SWD ACK codes and FSM states.
package dap_swd_xfer_engine_pkg;

  localparam logic [3:0] SEQ_CMD_SWD_TRANSFER = 4'h2;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;
  localparam logic [2:0] ACK_NOACK = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RX,
    ST_GAP,
    ST_RESP
  } xfer_state_e;

  function automatic logic [15:0] swd_xfer_cmd(input logic [1:0] addr,
                                               input logic       rnw,
                                               input logic       apndp);
    return {SEQ_CMD_SWD_TRANSFER, 8'd0, addr, rnw, apndp};
  endfunction

endpackage

// File: rtl/dap_swd_xfer_engine_edge_rise.sv
// Registered rising-edge detector for the sequencer's synchronized result level.
module dap_edge_rise (
  input  logic clk,
  input  logic resetn,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!resetn) prev_q <= 1'b0;
    else         prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/dap_swd_xfer_engine.sv
// Issues one SWD transfer per DAP request to the sequencer, retries on WAIT, returns one response.
// Optional read parity checking is enabled by defining DAP_XFER_PARITY_CHECK_EN.
module dap_swd_xfer_engine
  import dap_swd_xfer_engine_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned RETRY_W        = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_apndp,
  input  logic               req_rnw,
  input  logic [1:0]         req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [RETRY_W-1:0] wait_retry,
  input  logic               abort,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_ack,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_perr,
  output logic [RETRY_W-1:0] rsp_retries,
  output logic               seq_tx_valid,
  output logic [15:0]        seq_tx_cmd,
  output logic [63:0]        seq_tx_data,
  input  logic               seq_tx_full,
  input  logic               seq_rx_valid,
  input  logic [15:0]        seq_rx_flag,
  input  logic [63:0]        seq_rx_data,
  output logic               busy
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  xfer_state_e        state_q, state_d;
  logic               ready_q, ready_d;
  logic               tx_valid_q, tx_valid_d;
  logic [15:0]        cmd_q, cmd_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rnw_q, rnw_d;
  logic [RETRY_W-1:0] limit_q, limit_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [2:0]         ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rx_rise;

  dap_edge_rise u_rx_edge (
    .clk    (clk),
    .resetn (resetn),
    .sig_i  (seq_rx_valid),
    .rise_o (rx_rise)
  );

`ifdef DAP_XFER_PARITY_CHECK_EN
  logic par_q, par_d;
  logic unused_rx_bits;
  assign unused_rx_bits = ^{seq_rx_flag[15:3], seq_rx_data[63:33]};
`else
  logic unused_rx_bits;
  assign unused_rx_bits = ^{seq_rx_flag[15:3], seq_rx_data[63:33], seq_rx_data[0]};
`endif

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    rnw_d      = rnw_q;
    limit_d    = limit_q;
    retries_d  = retries_q;
    to_d       = to_q;
    ack_d      = ack_q;
    rdata_d    = rdata_q;
`ifdef DAP_XFER_PARITY_CHECK_EN
    par_d      = par_q;
`endif
    // Low-time counter runs whenever the strobe is low, saturating once the gap is met.
    gap_d      = (!tx_valid_q && (gap_q != GAP_MAX)) ? gap_q + GAP_W'(1) : gap_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          cmd_d     = swd_xfer_cmd(req_addr, req_rnw, req_apndp);
          wdata_d   = req_wdata;
          rnw_d     = req_rnw;
          limit_d   = wait_retry;
          retries_d = '0;
          ack_d     = '0;
          rdata_d   = '0;
`ifdef DAP_XFER_PARITY_CHECK_EN
          par_d     = 1'b0;
`endif
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if ((gap_q == GAP_MAX) && !seq_tx_full) begin
          tx_valid_d = 1'b1;
          to_d       = TO_W'(TIMEOUT_CYCLES);
          state_d    = ST_WAIT_RX;
        end
      end
      ST_WAIT_RX: begin
        // A result edge wins over a timeout expiring in the same cycle.
        if (rx_rise) begin
          ack_d = seq_rx_flag[2:0];
          if (rnw_q) begin
            rdata_d = seq_rx_data[32:1];
`ifdef DAP_XFER_PARITY_CHECK_EN
            par_d   = seq_rx_data[0];
`endif
          end
          tx_valid_d = 1'b0;
          gap_d      = '0;
          state_d    = ST_GAP;
        end else if (to_q == '0) begin
          ack_d      = ACK_NOACK;
          tx_valid_d = 1'b0;
          gap_d      = '0;
          state_d    = ST_GAP;
        end else begin
          to_d = to_q - TO_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q >= GAP_LAST) begin
          if ((ack_q == ACK_WAIT) && (retries_q < limit_q) && !abort) begin
            retries_d = retries_q + RETRY_W'(1);
            state_d   = ST_ISSUE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      cmd_q      <= '0;
      wdata_q    <= '0;
      rnw_q      <= 1'b0;
      limit_q    <= '0;
      retries_q  <= '0;
      gap_q      <= GAP_MAX;
      to_q       <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
`ifdef DAP_XFER_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      tx_valid_q <= tx_valid_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      rnw_q      <= rnw_d;
      limit_q    <= limit_d;
      retries_q  <= retries_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
`ifdef DAP_XFER_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign req_ready    = ready_q;
  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_ack      = ack_q;
  assign rsp_rdata    = ((ack_q == ACK_OK) && rnw_q) ? rdata_q : '0;
  assign rsp_retries  = retries_q;
  assign seq_tx_valid = tx_valid_q;
  assign seq_tx_cmd   = cmd_q;
  assign seq_tx_data  = {32'd0, wdata_q};

`ifdef DAP_XFER_PARITY_CHECK_EN
  assign rsp_perr = (ack_q == ACK_OK) && rnw_q && ((^rdata_q) ^ par_q);
`else
  assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_dap_swd_xfer_engine.sv
// Directed self-checking bench for dap_swd_xfer_engine with a small behavioural sequencer model.
module tb_dap_swd_xfer_engine;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_apndp, req_rnw;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic [15:0] wait_retry;
  logic        abort;
  logic        rsp_valid, rsp_ready, rsp_perr;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic [15:0] rsp_retries;
  logic        seq_tx_valid, seq_tx_full, seq_rx_valid, busy;
  logic [15:0] seq_tx_cmd, seq_rx_flag;
  logic [63:0] seq_tx_data, seq_rx_data;

  always #5 clk = ~clk;

  dap_swd_xfer_engine #(
    .GAP_CYCLES     (8),
    .TIMEOUT_CYCLES (100),
    .RETRY_W        (16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_apndp    (req_apndp),
    .req_rnw      (req_rnw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .wait_retry   (wait_retry),
    .abort        (abort),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_ack      (rsp_ack),
    .rsp_rdata    (rsp_rdata),
    .rsp_perr     (rsp_perr),
    .rsp_retries  (rsp_retries),
    .seq_tx_valid (seq_tx_valid),
    .seq_tx_cmd   (seq_tx_cmd),
    .seq_tx_data  (seq_tx_data),
    .seq_tx_full  (seq_tx_full),
    .seq_rx_valid (seq_rx_valid),
    .seq_rx_flag  (seq_rx_flag),
    .seq_rx_data  (seq_rx_data),
    .busy         (busy)
  );

`ifdef DAP_XFER_PARITY_CHECK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Scripted answers, written by the stimulus block only.
  int          mode;
  logic [2:0]  script_ack [4];
  logic [31:0] script_rdata;
  logic        script_par;

  // Observations, written by the sequencer model only.
  int          issue_cnt, high_cnt, low_cnt, min_gap, dly, hold, idx;
  bit          seen, tx_prev, busy_prev, pending;
  logic [15:0] cap_cmd;
  logic [63:0] cap_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sequencer model: answers each rising strobe after 3 cycles, holds the result level 2 cycles.
  initial begin
    seq_rx_valid = 1'b0; seq_rx_flag = '0; seq_rx_data = '0;
    issue_cnt = 0; high_cnt = 0; low_cnt = 0; min_gap = 1000; dly = 0; hold = 0; idx = 0;
    seen = 0; tx_prev = 0; busy_prev = 0; pending = 0; cap_cmd = '0; cap_data = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        seq_rx_valid = 1'b0; pending = 0; hold = 0; tx_prev = 0; busy_prev = 0;
      end else begin
        if (busy && !busy_prev) begin
          issue_cnt = 0; high_cnt = 0; low_cnt = 0; min_gap = 1000; seen = 0;
        end
        if (seq_tx_valid) begin
          high_cnt++;
          if (!tx_prev) begin
            if (seen && low_cnt < min_gap) min_gap = low_cnt;
            seen = 1; issue_cnt++;
            cap_cmd = seq_tx_cmd; cap_data = seq_tx_data;
            if (mode == 0) begin pending = 1; dly = 3; end
          end
          low_cnt = 0;
        end else begin
          low_cnt++;
        end
        if (hold > 0) begin
          hold--;
          if (hold == 0) seq_rx_valid = 1'b0;
        end else if (pending) begin
          dly--;
          if (dly == 0) begin
            pending = 0; hold = 2;
            idx = (issue_cnt > 4) ? 3 : issue_cnt - 1;
            seq_rx_flag  = {13'd0, script_ack[idx]};
            seq_rx_data  = {31'd0, script_rdata, script_par};
            seq_rx_valid = 1'b1;
          end
        end
        tx_prev = seq_tx_valid; busy_prev = busy;
      end
    end
  end

  task automatic run_req(input logic ap, input logic rnw, input logic [1:0] addr,
                         input logic [31:0] wd, input logic [15:0] lim);
    bit got;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    req_apndp = ap; req_rnw = rnw; req_addr = addr; req_wdata = wd; wait_retry = lim;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    check("rsp_arrived", got, 1'b1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", rsp_valid, 1'b0);
    check("ready_after_rsp", req_ready, 1'b1);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_apndp = 1'b0; req_rnw = 1'b0; req_addr = '0;
    req_wdata = '0; wait_retry = '0; abort = 1'b0; rsp_ready = 1'b0; seq_tx_full = 1'b0;
    mode = 0; script_rdata = '0; script_par = 1'b0;
    for (int i = 0; i < 4; i++) script_ack[i] = 3'b001;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_tx_valid", seq_tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_cmd", seq_tx_cmd, 16'h0000);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1'b1);

    // Read DP 0x0, OK, good parity (0x2BA01477 has 14 ones)
    script_ack[0] = 3'b001; script_rdata = 32'h2BA01477; script_par = 1'b0;
    run_req(1'b0, 1'b1, 2'd0, 32'h0, 16'd0);
    check("rd_ack", rsp_ack, 3'b001);
    check("rd_rdata", rsp_rdata, 32'h2BA01477);
    check("rd_perr", rsp_perr, 1'b0);
    check("rd_retries", rsp_retries, 16'd0);
    check("rd_cmd", cap_cmd, 16'h2002);
    check("rd_issues", issue_cnt, 1);
    finish_rsp();

    // Write AP addr=1
    script_rdata = 32'h12345678;
    run_req(1'b1, 1'b0, 2'd1, 32'hDEADBEEF, 16'd0);
    check("wr_cmd_low", cap_cmd[3:0], 4'b0101);
    check("wr_cmd", cap_cmd, 16'h2005);
    check("wr_data", cap_data, 64'h00000000DEADBEEF);
    check("wr_ack", rsp_ack, 3'b001);
    check("wr_rdata", rsp_rdata, 32'h0);
    finish_rsp();

    // WAIT, WAIT, OK with limit 3 (0xA5A50001 has 9 ones -> parity 1)
    script_ack[0] = 3'b010; script_ack[1] = 3'b010; script_ack[2] = 3'b001; script_ack[3] = 3'b001;
    script_rdata = 32'hA5A50001; script_par = 1'b1;
    run_req(1'b1, 1'b1, 2'd3, 32'h0, 16'd3);
    check("ww_issues", issue_cnt, 3);
    check("ww_gap_ok", (min_gap >= 8), 1'b1);
    check("ww_retries", rsp_retries, 16'd2);
    check("ww_ack", rsp_ack, 3'b001);
    check("ww_rdata", rsp_rdata, 32'hA5A50001);
    check("ww_perr", rsp_perr, 1'b0);
    finish_rsp();

    // Always WAIT, limit 2
    for (int i = 0; i < 4; i++) script_ack[i] = 3'b010;
    run_req(1'b0, 1'b0, 2'd2, 32'h5, 16'd2);
    check("aw_issues", issue_cnt, 3);
    check("aw_ack", rsp_ack, 3'b010);
    check("aw_retries", rsp_retries, 16'd2);
    check("aw_rdata", rsp_rdata, 32'h0);
    finish_rsp();

    // Always WAIT, limit 2, abort held through the first GAP
    abort = 1'b1;
    run_req(1'b0, 1'b1, 2'd2, 32'h0, 16'd2);
    abort = 1'b0;
    check("ab_issues", issue_cnt, 1);
    check("ab_ack", rsp_ack, 3'b010);
    check("ab_retries", rsp_retries, 16'd0);
    finish_rsp();

    // WAIT with limit 0 returns immediately
    run_req(1'b0, 1'b1, 2'd1, 32'h0, 16'd0);
    check("w0_issues", issue_cnt, 1);
    check("w0_ack", rsp_ack, 3'b010);
    check("w0_retries", rsp_retries, 16'd0);
    finish_rsp();

    // No response: timeout after 101 strobe-high cycles
    mode = 1;
    run_req(1'b0, 1'b1, 2'd0, 32'h0, 16'd4);
    check("to_high_cycles", high_cnt, 101);
    check("to_ack", rsp_ack, 3'b111);
    check("to_tx_low", seq_tx_valid, 1'b0);
    check("to_rdata", rsp_rdata, 32'h0);
    check("to_issues", issue_cnt, 1);
    finish_rsp();
    mode = 0;

    // Read with flipped parity, response held 10 cycles
    for (int i = 0; i < 4; i++) script_ack[i] = 3'b001;
    script_rdata = 32'h2BA01477; script_par = 1'b1;
    run_req(1'b0, 1'b1, 2'd0, 32'h0, 16'd0);
    check("pe_perr", rsp_perr, PERR_EXP);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pe_hold", {rsp_valid, rsp_ack, rsp_rdata, rsp_perr}, {1'b1, 3'b001, 32'h2BA01477, PERR_EXP});
    end
    finish_rsp();

    // abort in IDLE does nothing
    abort = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_abort_busy", busy, 1'b0);
    check("idle_abort_ready", req_ready, 1'b1);
    abort = 1'b0;

    // Mid-operation reset
    mode = 1;
    req_apndp = 1'b1; req_rnw = 1'b1; req_addr = 2'd0; wait_retry = 16'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mr_tx_high", seq_tx_valid, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check("mr_tx_low", seq_tx_valid, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_ready", req_ready, 1'b0);
    resetn = 1'b1;
    mode = 0;
    @(negedge clk);
    check("mr_ready_back", req_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
